// File: rtl/memory_operand_fetch.sv
// memory_operand_fetch: fetches up to two memory source operands before issue.
// Define MEM_FETCH_SAME_ADDR_REUSE_EN so equal Src1/Src2 addresses share a single load.
module memory_operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        isAddressCalculationSuccessfulIn,
  output logic        canAddressCalculationOut,
  input  logic        isMemoryAccessSrc1In,
  input  logic        isMemoryAccessSrc2In,
  input  logic        isMemoryAccessDestIn,
  input  logic [0:63] memoryAddressSrc1In,
  input  logic [0:63] memoryAddressSrc2In,
  input  logic [0:63] memoryAddressDestIn,
  input  logic [0:63] operand1ValIn,
  input  logic [0:63] operand2ValIn,
  input  logic [0:7]  opcodeIn,
  input  logic [0:3]  destRegIn,
  output logic        memReqValidOut,
  input  logic        memReqReadyIn,
  output logic [0:63] memReqAddrOut,
  input  logic        memRespValidIn,
  input  logic [0:63] memRespDataIn,
  output logic [0:63] operand1ValOut,
  output logic [0:63] operand2ValOut,
  output logic [0:7]  opcodeOut,
  output logic [0:3]  destRegOut,
  output logic        isMemoryAccessDestOut,
  output logic [0:63] memoryAddressDestOut,
  output logic        operandsValidOut,
  input  logic        canExecuteIn
);
  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE} state_t;
  state_t      state_q, state_d;
  logic        src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
  logic [0:63] addr1_q, addr1_d, addr2_q, addr2_d, addr_dst_q, addr_dst_d;
  logic [0:63] op1_q, op1_d, op2_q, op2_d;
  logic [0:7]  opcode_q, opcode_d;
  logic [0:3]  dest_reg_q, dest_reg_d;
  logic        same_addr;
`ifdef MEM_FETCH_SAME_ADDR_REUSE_EN
  assign same_addr = src2_q && (addr1_q == addr2_q);
`else
  assign same_addr = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    dst_d      = dst_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    addr_dst_d = addr_dst_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    opcode_d   = opcode_q;
    dest_reg_d = dest_reg_q;
    case (state_q)
      IDLE: if (isAddressCalculationSuccessfulIn) begin
        src1_d     = isMemoryAccessSrc1In;
        src2_d     = isMemoryAccessSrc2In;
        dst_d      = isMemoryAccessDestIn;
        addr1_d    = memoryAddressSrc1In;
        addr2_d    = memoryAddressSrc2In;
        addr_dst_d = memoryAddressDestIn;
        op1_d      = operand1ValIn;
        op2_d      = operand2ValIn;
        opcode_d   = opcodeIn;
        dest_reg_d = destRegIn;
        state_d    = isMemoryAccessSrc1In ? REQ1 : isMemoryAccessSrc2In ? REQ2 : DONE;
      end
      REQ1:  state_d = memReqReadyIn ? WAIT1 : REQ1;
      WAIT1: if (memRespValidIn) begin
        op1_d   = memRespDataIn;
        op2_d   = same_addr ? memRespDataIn : op2_q;
        state_d = (src2_q && !same_addr) ? REQ2 : DONE;
      end
      REQ2:  state_d = memReqReadyIn ? WAIT2 : REQ2;
      WAIT2: if (memRespValidIn) begin
        op2_d   = memRespDataIn;
        state_d = DONE;
      end
      DONE:    state_d = canExecuteIn ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      src1_q     <= 1'b0;
      src2_q     <= 1'b0;
      dst_q      <= 1'b0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      addr_dst_q <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      opcode_q   <= '0;
      dest_reg_q <= '0;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      dst_q      <= dst_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      addr_dst_q <= addr_dst_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      opcode_q   <= opcode_d;
      dest_reg_q <= dest_reg_d;
    end
  end
  assign canAddressCalculationOut = state_q == IDLE;
  assign memReqValidOut           = (state_q == REQ1) || (state_q == REQ2);
  assign memReqAddrOut            = state_q == REQ1 ? addr1_q : state_q == REQ2 ? addr2_q : '0;
  assign operandsValidOut         = state_q == DONE;
  assign operand1ValOut           = op1_q;
  assign operand2ValOut           = op2_q;
  assign opcodeOut                = opcode_q;
  assign destRegOut               = dest_reg_q;
  assign isMemoryAccessDestOut    = dst_q;
  assign memoryAddressDestOut     = addr_dst_q;
endmodule

// File: tb/tb_memory_operand_fetch.sv
// tb_memory_operand_fetch: randomized and directed checks against a transaction-level model
// that predicts the ordered request list and the final operand values.
module tb_memory_operand_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, can_addr, s1_in, s2_in, sd_in;
  logic [0:63] a1_in, a2_in, ad_in, o1_in, o2_in;
  logic [0:7]  opc_in;
  logic [0:3]  dr_in;
  logic        req_valid, req_ready, resp_valid, ops_valid, can_exec;
  logic [0:63] req_addr, resp_data, op1_out, op2_out, ad_out;
  logic [0:7]  opc_out;
  logic [0:3]  dr_out;
  logic        sd_out;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mem_ov [logic [63:0]];

  memory_operand_fetch dut (
    .clk(clk), .reset(reset),
    .isAddressCalculationSuccessfulIn(valid_in), .canAddressCalculationOut(can_addr),
    .isMemoryAccessSrc1In(s1_in), .isMemoryAccessSrc2In(s2_in), .isMemoryAccessDestIn(sd_in),
    .memoryAddressSrc1In(a1_in), .memoryAddressSrc2In(a2_in), .memoryAddressDestIn(ad_in),
    .operand1ValIn(o1_in), .operand2ValIn(o2_in), .opcodeIn(opc_in), .destRegIn(dr_in),
    .memReqValidOut(req_valid), .memReqReadyIn(req_ready), .memReqAddrOut(req_addr),
    .memRespValidIn(resp_valid), .memRespDataIn(resp_data),
    .operand1ValOut(op1_out), .operand2ValOut(op2_out), .opcodeOut(opc_out), .destRegOut(dr_out),
    .isMemoryAccessDestOut(sd_out), .memoryAddressDestOut(ad_out),
    .operandsValidOut(ops_valid), .canExecuteIn(can_exec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    return mem_ov.exists(a) ? mem_ov[a] : ((a * 64'd3) ^ 64'hC3C3_5A5A_0F0F_9696);
  endfunction

  task automatic scramble_payload();
    s1_in = 1'($urandom); s2_in = 1'($urandom); sd_in = 1'($urandom);
    a1_in = {$urandom, $urandom}; a2_in = {$urandom, $urandom}; ad_in = {$urandom, $urandom};
    o1_in = {$urandom, $urandom}; o2_in = {$urandom, $urandom};
    opc_in = 8'($urandom); dr_in = 4'($urandom);
  endtask

  task automatic run_txn(input logic s1, input logic s2, input logic sd,
                         input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] ad,
                         input logic [63:0] o1, input logic [63:0] o2,
                         input logic [7:0] opc, input logic [3:0] dr,
                         input int rdy_stall, input int resp_dly, input int exec_stall, input int exp_lat);
    logic [63:0] q[$];
    logic [63:0] e1, e2, cur;
    int st, rd, es, nreq, req_cycles;
    bit inflight, done, seen;
    e1 = s1 ? mem_data(a1) : o1;
    e2 = s2 ? mem_data(a2) : o2;
    if (s1) q.push_back(a1);
`ifdef MEM_FETCH_SAME_ADDR_REUSE_EN
    if (s2 && !(s1 && a1 == a2)) q.push_back(a2);
`else
    if (s2) q.push_back(a2);
`endif
    nreq = q.size();
    chk("ready_in_idle", can_addr, 1);
    valid_in = 1; s1_in = s1; s2_in = s2; sd_in = sd;
    a1_in = a1; a2_in = a2; ad_in = ad; o1_in = o1; o2_in = o2; opc_in = opc; dr_in = dr;
    resp_valid = 1; resp_data = {$urandom, $urandom};
    req_ready = 0; can_exec = 0;
    @(posedge clk); #1;
    valid_in = 0;
    st = rdy_stall; rd = 0; es = exec_stall; inflight = 0; done = 0; seen = 0; req_cycles = 0; cur = '0;
    for (int cyc = 1; cyc < 300 && !done; cyc++) begin
      scramble_payload();
      req_ready = 0; can_exec = 0;
      resp_valid = inflight ? 1'b0 : 1'($urandom);
      resp_data = {$urandom, $urandom};
      if (inflight) begin
        chk("no_req_while_waiting", req_valid, 0);
        if (rd == 0) begin
          resp_valid = 1; resp_data = mem_data(cur); inflight = 0;
        end else rd--;
      end else if (req_valid) begin
        req_cycles++;
        if (q.size() == 0) chk("unexpected_req", req_valid, 0);
        else begin
          chk("req_addr", req_addr, q[0]);
          if (st == 0) begin
            req_ready = 1; cur = q.pop_front(); inflight = 1; rd = resp_dly; st = rdy_stall;
          end else st--;
        end
      end
      if (ops_valid) begin
        if (!seen) begin
          seen = 1;
          chk("reqs_outstanding", q.size(), 0);
          if (exp_lat >= 0) chk("latency", cyc, exp_lat);
        end
        chk("op1", op1_out, e1);
        chk("op2", op2_out, e2);
        chk("opcode", opc_out, opc);
        chk("dest_reg", dr_out, dr);
        chk("dest_flag", sd_out, sd);
        chk("dest_addr", ad_out, ad);
        chk("busy_in_done", can_addr, 0);
        chk("no_req_in_done", req_valid, 0);
        if (es == 0) begin can_exec = 1; done = 1; end else es--;
      end
      @(posedge clk); #1;
    end
    can_exec = 0; req_ready = 0; resp_valid = 0;
    chk("completed", done, 1);
    chk("req_cycle_count", req_cycles, nreq * (rdy_stall + 1));
    chk("idle_after", can_addr, 1);
    chk("valid_low_after", ops_valid, 0);
  endtask

  initial begin
    logic [63:0] a;
    reset = 0; valid_in = 0; req_ready = 0; resp_valid = 0; can_exec = 0; resp_data = '0;
    scramble_payload();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_can_addr", can_addr, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_ops_valid", ops_valid, 0);
    chk("rst_op1", op1_out, 0);
    chk("rst_op2", op2_out, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_dest_addr", ad_out, 0);
    reset = 1;
    @(posedge clk); #1;
    run_txn(0, 0, 0, 64'h0, 64'h0, 64'h0, 64'd5, 64'd7, 8'h12, 4'h3, 0, 0, 0, 1);
    mem_ov[64'h1000] = 64'hDEAD;
    run_txn(1, 0, 1, 64'h1000, 64'h9, 64'h500, 64'h1, 64'h77, 8'h34, 4'h5, 3, 0, 0, 6);
    mem_ov[64'h2000] = 64'hBEEF;
    run_txn(1, 0, 0, 64'h2000, 64'h0, 64'h0, 64'h1, 64'h2, 8'h01, 4'h1, 0, 0, 0, 3);
    mem_ov[64'h20] = 64'h11;
    mem_ov[64'h40] = 64'h22;
    run_txn(1, 1, 0, 64'h20, 64'h40, 64'h0, 64'h3, 64'h4, 8'h56, 4'h7, 0, 0, 0, 5);
    mem_ov[64'h80] = 64'h33;
`ifdef MEM_FETCH_SAME_ADDR_REUSE_EN
    run_txn(1, 1, 0, 64'h80, 64'h80, 64'h0, 64'h5, 64'h6, 8'h78, 4'h9, 0, 0, 0, 3);
`else
    run_txn(1, 1, 0, 64'h80, 64'h80, 64'h0, 64'h5, 64'h6, 8'h78, 4'h9, 0, 0, 0, 5);
`endif
    run_txn(0, 1, 1, 64'h0, 64'h3000, 64'h4000, 64'hAA, 64'hBB, 8'h9A, 4'hB, 1, 2, 5, -1);
    // Reset while a load is outstanding; the late response must not land anywhere.
    valid_in = 1; s1_in = 1; s2_in = 0; sd_in = 0; a1_in = 64'h5000; o1_in = 64'h1; o2_in = 64'h2;
    @(posedge clk); #1;
    valid_in = 0; req_ready = 1;
    chk("pre_rst_req", req_valid, 1);
    @(posedge clk); #1;
    req_ready = 0; reset = 0;
    @(posedge clk); #1;
    reset = 1;
    chk("midrst_can_addr", can_addr, 1);
    chk("midrst_req_valid", req_valid, 0);
    chk("midrst_op1", op1_out, 0);
    resp_valid = 1; resp_data = 64'hFEED;
    @(posedge clk); #1;
    resp_valid = 0;
    chk("stale_idle", can_addr, 1);
    chk("stale_ops_valid", ops_valid, 0);
    chk("stale_op1", op1_out, 0);
    mem_ov[64'h6000] = 64'h600D;
    run_txn(1, 0, 0, 64'h6000, 64'h0, 64'h0, 64'h1, 64'h2, 8'h11, 4'h2, 0, 0, 0, 3);
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), a,
              ($urandom_range(0, 2) == 0) ? a : {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_operand_fetch.md
MEMORY_OPERAND_FETCH -- requirements
Module: MemoryOperandFetch

Interface
REQ-001 SHALL have no parameters; all datapath widths are fixed as listed.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port isAddressCalculationSuccessfulIn  input  1  upstream instruction valid.
REQ-005 SHALL have port canAddressCalculationOut  output  1  upstream ready; high only in IDLE.
REQ-006 SHALL have ports isMemoryAccessSrc1In, isMemoryAccessSrc2In, isMemoryAccessDestIn  input  1 each  memory-operand flags.
REQ-007 SHALL have ports memoryAddressSrc1In, memoryAddressSrc2In, memoryAddressDestIn  input  [0:63]  computed addresses.
REQ-008 SHALL have ports operand1ValIn, operand2ValIn  input  [0:63]  register operand values; opcodeIn  input  [0:7]; destRegIn  input  [0:3].
REQ-009 SHALL have ports memReqValidOut  output  1; memReqReadyIn  input  1; memReqAddrOut  output  [0:63]  read-request handshake.
REQ-010 SHALL have ports memRespValidIn  input  1; memRespDataIn  input  [0:63]  read response.
REQ-011 SHALL have ports operand1ValOut, operand2ValOut  output  [0:63]; opcodeOut  [0:7]; destRegOut  [0:3]; isMemoryAccessDestOut  1; memoryAddressDestOut  [0:63]; operandsValidOut  output  1.
REQ-012 SHALL have port canExecuteIn  input  1  downstream ready.

Function
REQ-013 SHALL implement FSM states IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE.
REQ-014 Accept: in IDLE with isAddressCalculationSuccessfulIn=1, register all *In payload fields; next state REQ1 if Src1 flag, else REQ2 if Src2 flag, else DONE.
REQ-015 REQ1/REQ2: memReqValidOut=1, memReqAddrOut=registered Src1/Src2 address, held stable until memReqReadyIn=1; on that cycle go to WAIT1/WAIT2.
REQ-016 WAIT1: on memRespValidIn=1, operand1 register = memRespDataIn; next REQ2 if Src2 flag else DONE; WAIT2: operand2 register = memRespDataIn; next DONE.
REQ-017 Non-memory operands SHALL keep the registered operand1ValIn/operand2ValIn unchanged.
REQ-018 DONE: operandsValidOut=1 with stable outputs until canExecuteIn=1; on that cycle return to IDLE.
REQ-019 memRespValidIn outside WAIT1/WAIT2, including the cycle a request is accepted, SHALL be ignored.
REQ-020 At most one request outstanding; Dest address SHALL NOT be fetched, only forwarded.
REQ-021 Latency: no memory operand -> operandsValidOut the cycle after accept; one load with ready=1 and response one cycle later -> 3 cycles after accept.
REQ-022 memReqValidOut=0 and operandsValidOut=0 in all other states.

Reset
REQ-023 reset=0 at a clock edge SHALL force IDLE from any state, abandoning any in-flight request; later responses are ignored per REQ-019.
REQ-024 Reset values: all data outputs 0, memReqValidOut=0, operandsValidOut=0; canAddressCalculationOut=1 from the first cycle after reset.

Configuration
REQ-025 MEM_FETCH_SAME_ADDR_REUSE_EN defined: if Src1 and Src2 flags are both set and addresses are equal, WAIT1 SHALL copy the response into both operands and go to DONE, skipping REQ2.
REQ-026 Without MEM_FETCH_SAME_ADDR_REUSE_EN: two requests SHALL always be issued for two memory sources.

Verification
REQ-027 Register-only, op1=5, op2=7 -> operandsValidOut one cycle after accept, outputs 5/7, no memReqValidOut.
REQ-028 Src1 load at 0x1000, memReqReadyIn low 3 cycles, response 0xDEAD -> address held stable 4 cycles; operand1ValOut=0xDEAD; operand2ValOut=register value.
REQ-029 Src1 at 0x20, Src2 at 0x40, responses 0x11/0x22 -> requests issued in order 0x20 then 0x40; outputs 0x11/0x22.
REQ-030 Both sources at 0x80, response 0x33 -> with macro: one request, outputs 0x33/0x33; without macro: two requests.
REQ-031 reset=0 during WAIT1, then a stale response -> IDLE, response ignored, next instruction fetched correctly.
REQ-032 canExecuteIn low 5 cycles in DONE -> outputs stable and canAddressCalculationOut=0 throughout.
